// File: rtl/dmem_ctrl.sv
// Valid/ready request/response front end for the 1-cycle-latency data RAM.
// Optional address bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [31:0]                  req_addr_i,
    input  logic                         req_we_i,
    input  logic [31:0]                  req_wdata_i,
    input  logic [3:0]                   req_wstrb_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [31:0]                  rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         ram_en_o,
    output logic                         ram_wen_o,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_addr_o,
    output logic [31:0]                  ram_wdata_o,
    output logic [3:0]                   ram_wstrb_o,
    input  logic [31:0]                  ram_rdata_i
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        armed;
    logic        is_load_q;
    logic        accept;
    logic        fault;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign offset             = req_addr_i - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] SPAN     = 33'(MEM_DEPTH) << 2;

    logic err_q;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    assign fault = ({1'b0, req_addr_i} < BASE_EXT) |
                   ({1'b0, req_addr_i} >= (BASE_EXT + SPAN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= fault;
        end
    end

    assign rsp_err_o = rsp_valid_o & err_q;
`else
    assign fault     = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // armed keeps req_ready_o low until the first clock edge after reset release
    assign req_ready_o = armed & ((state == IDLE) | rsp_ready_i);
    assign accept      = req_valid_i & req_ready_o;

    assign ram_en_o    = accept & ~fault;
    assign ram_wen_o   = ram_en_o & req_we_i;
    assign ram_addr_o  = offset[AW+1:2];
    assign ram_wdata_o = req_wdata_i;
    assign ram_wstrb_o = req_wstrb_i;

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = RESP;
        end else if ((state == RESP) && rsp_ready_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            armed     <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (accept) begin
                is_load_q <= ~req_we_i & ~fault;
            end
        end
    end

    // ram output register only moves on ram_en_o, which is blocked while a response stalls
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = (rsp_valid_o & is_load_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a behavioural 1-cycle-latency RAM attached.
// Expectations follow DMEM_BOUNDS_CHECK_EN when the bench is built with it defined.
module tb_dmem_ctrl;

    localparam int unsigned MEM_DEPTH = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned AW        = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_we;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_rdata;

    logic [31:0] ram_mem [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];
    rsp_t        sb [$];

    int  n_cmp;
    int  n_bad;
    int  en_count;
    bit  model_valid;
    bit  armed;
    bit  rand_done;

    dmem_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .ram_en_o    (ram_en),
        .ram_wen_o   (ram_wen),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wstrb_o (ram_wstrb),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered read of the pre-write word, byte-strobed write, no reset
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            if (ram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit fault_of(input logic [31:0] addr);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (addr < BASE_ADDR) ||
               ({1'b0, addr} >= ({1'b0, BASE_ADDR} + 33'(MEM_DEPTH) * 33'd4));
`else
        return (addr === 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (off >> 2) % MEM_DEPTH;
    endfunction

    // Monitor: protocol model, RAM strobe checks, scoreboard push on accept / compare on response
    always @(negedge clk) begin
        bit          acc;
        bit          flt;
        int unsigned idx;
        rsp_t        exp_rsp;
        if (!rst_n) begin
            model_valid = 1'b0;
            armed       = 1'b0;
            sb.delete();
        end else begin
            acc = req_valid && req_ready;
            check("req_ready", {31'b0, req_ready}, {31'b0, armed && (!model_valid || rsp_ready)});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, model_valid});
            if (model_valid) begin
                if (sb.size() > 0) begin
                    exp_rsp = sb[0];
                    check("rsp_rdata", rsp_rdata, exp_rsp.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_rsp.err});
                    if (rsp_ready) void'(sb.pop_front());
                end else begin
                    check("sb_underflow", 32'd0, 32'd1);
                end
            end
            flt = acc && fault_of(req_addr);
            idx = idx_of(req_addr);
            check("ram_en", {31'b0, ram_en}, {31'b0, acc && !flt});
            check("ram_wen", {31'b0, ram_wen}, {31'b0, acc && !flt && req_we});
            if (acc && !flt) begin
                check("ram_addr", {{(32-AW){1'b0}}, ram_addr}, idx);
                if (req_we) begin
                    check("ram_wdata", ram_wdata, req_wdata);
                    check("ram_wstrb", {28'b0, ram_wstrb}, {28'b0, req_wstrb});
                end
            end
            if (acc) begin
                exp_rsp.err   = flt;
                exp_rsp.rdata = 32'h0;
                if (!flt && req_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wstrb[b]) ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else if (!flt) begin
                    exp_rsp.rdata = ref_mem[idx];
                end
                sb.push_back(exp_rsp);
            end
            if (ram_en) en_count++;
            model_valid = acc || (model_valid && !rsp_ready);
            armed       = 1'b1;
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e0;
        n_cmp     = 0;
        n_bad     = 0;
        en_count  = 0;
        rand_done = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            ram_mem[i] = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end

        idle(1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        #1;
        check("release_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("release_ready_high", {31'b0, req_ready}, 32'd1);

        // store then load: response one cycle after accept
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        send(1'b0, 32'h10, 32'h0, 4'h0);
        check("t1_latency_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_load_data", rsp_rdata, 32'hDEAD_BEEF);
        idle(1);

        // byte merge
        send(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
        send(1'b0, 32'h10, 32'h0, 4'h0);
        check("t2_merge_data", rsp_rdata, 32'hDEAD_BEAA);
        idle(1);

        // backpressure with a second request waiting
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        e0 = en_count;
        fork
            send(1'b0, 32'h14, 32'h0, 4'h0);
            begin
                idle(3);
                check("t3_held_data", rsp_rdata, 32'hDEAD_BEAA);
                check("t3_no_strobe", en_count - e0, 32'd0);
                rsp_ready = 1'b1;
            end
        join
        idle(2);

        // four back-to-back loads
        e0 = en_count;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        send(1'b0, 32'h14, 32'h0, 4'h0);
        send(1'b0, 32'h18, 32'h0, 4'h0);
        send(1'b0, 32'h1C, 32'h0, 4'h0);
        idle(2);
        check("t4_en_cycles", en_count - e0, 32'd4);

        // out-of-range load: faults with bounds checking, aliases word 0 without
        send(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        send(1'b0, 32'h400, 32'h0, 4'h0);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("t5_err", {31'b0, rsp_err}, 32'd1);
        check("t5_rdata", rsp_rdata, 32'h0);
`else
        check("t5_err", {31'b0, rsp_err}, 32'd0);
        check("t5_alias", rsp_rdata, 32'hCAFE_F00D);
`endif
        idle(1);

        // random traffic with random response backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] a;
                    a = {$urandom_range(0, 1) ? 22'h0 : 22'($urandom_range(0, 3)),
                         8'($urandom), 2'($urandom)};
                    send(1'($urandom), a, $urandom, 4'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rsp_ready = 1'($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                rsp_ready = 1'b1;
            end
        join
        idle(3);

        // reset while a response is held
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_rst_ready", {31'b0, req_ready}, 32'd0);
        idle(2);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        idle(1);
        send(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        send(1'b0, 32'h20, 32'h0, 4'h0);
        check("t6_post_rst_data", rsp_rdata, 32'h1234_5678);
        idle(3);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
